// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bridge
//  Description : Data-side bridge from the M-stage access request to the
//                SRAM-like req/addr_ok/data_ok data bus. Stalls the pipeline
//                while an access is in flight and holds the loaded word
//                until the pipeline advances past the instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
    parameter int ADDR_MAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush_except,
    input  logic        longest_stall,
    output logic [31:0] readdata,
    output logic        d_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] c_physMask = 32'h1FFF_FFFF;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rdataNext;
    logic        r_cancel;
    logic        w_cancelNext;
    logic        w_start;
    logic        w_isLoad;
    logic [31:0] w_physAddr;

    assign w_start  = mem_en & ~flush_except;
    assign w_isLoad = (mem_wen == 4'b0000);

    // kseg0/kseg1 windows fold onto the low 512 MB of physical space
    if (ADDR_MAP != 0) begin : g_addrMap
        assign w_physAddr = ((mem_addr[31:29] == 3'b100) || (mem_addr[31:29] == 3'b101))
                          ? (mem_addr & c_physMask) : mem_addr;
    end else begin : g_addrPass
        assign w_physAddr = mem_addr;
    end

    // Request fields come straight from the M stage, which d_stall keeps frozen
    assign data_wr    = ~w_isLoad;
    assign data_addr  = w_isLoad ? {w_physAddr[31:2], 2'b00} : w_physAddr;
    assign data_wdata = mem_wdata;
    assign readdata   = r_rdata;

    // Transfer size: loads always fetch the full word, stores follow the byte enables
    always_comb begin
        data_size = 2'd2;
        if (!w_isLoad) begin
            case (mem_wen)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: data_size = 2'd0;
                4'b0011, 4'b1100:                   data_size = 2'd1;
                default:                            data_size = 2'd2;
            endcase
        end
    end

    // Next-state, cancel tracking and handshake outputs
    always_comb begin
        w_next       = r_state;
        w_cancelNext = r_cancel;
        w_rdataNext  = r_rdata;
        data_req     = 1'b0;
        d_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    data_req = 1'b1;
                    d_stall  = 1'b1;
                    w_next   = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req = 1'b1;
                d_stall  = 1'b1;
                if (flush_except) w_cancelNext = 1'b1;
                if (data_addr_ok) w_next = WAIT;
            end
            WAIT: begin
                d_stall = 1'b1;
                if (data_data_ok) begin
                    // A flush arriving together with data_ok still discards the data
                    if (r_cancel || flush_except) begin
                        w_cancelNext = 1'b0;
                        w_next       = IDLE;
                    end else begin
                        w_rdataNext = data_rdata;
                        w_next      = DONE;
                    end
                end else if (flush_except) begin
                    w_cancelNext = 1'b1;
                end
            end
            DONE: begin
                if (!longest_stall || flush_except) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State, result and cancel registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_rdata  <= 32'h0;
            r_cancel <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_rdata  <= w_rdataNext;
            r_cancel <= w_cancelNext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bridge
//  Description : Self-checking bench for dmem_bridge; the bench plays the
//                pipeline and the bus slave and predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush_except;
    logic        longest_stall;
    logic [31:0] readdata;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    int          nCmp = 0;
    int          nBad = 0;
    int          seenReqs = 0;
    int          expReqs = 0;
    logic [31:0] prevRead = 32'h0;

    dmem_bridge #(.ADDR_MAP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush_except (flush_except),
        .longest_stall(longest_stall),
        .readdata     (readdata),
        .d_stall      (d_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok)
    );

    always #5 clk = ~clk;

    // Accepted bus requests (req and addr_ok together at a rising edge)
    always @(posedge clk) begin
        if (rst && data_req && data_addr_ok) seenReqs <= seenReqs + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refAddr(input logic [31:0] a, input logic [3:0] wen);
        logic [31:0] p;
        p = (a >= 32'h8000_0000 && a < 32'hC000_0000) ? (a - (a / 32'h2000_0000) * 32'h2000_0000) : a;
        if (wen == 4'b0000) p = (p / 4) * 4;
        return p;
    endfunction

    function automatic logic [31:0] refSize(input logic [3:0] wen);
        if (wen == 4'b0000) return 32'd2;
        if (wen == 4'd1 || wen == 4'd2 || wen == 4'd4 || wen == 4'd8) return 32'd0;
        if (wen == 4'd3 || wen == 4'd12) return 32'd1;
        return 32'd2;
    endfunction

    task automatic quiet();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        flush_except = 1'b0;
        data_rdata   = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            quiet();
            mem_en = 1'b0;
            longest_stall = 1'b0;
            #1;
            chk("idle_stall", 32'(d_stall), 32'd0);
            chk("idle_req", 32'(data_req), 32'd0);
            chk("idle_readdata", readdata, prevRead);
        end
    endtask

    // One complete M-stage access: aokDly cycles before addr_ok, dokDly cycles
    // of WAIT before data_ok, optional flush on the first WAIT cycle, and
    // holdStall extra frozen cycles once the result is back.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int aokDly, input int dokDly,
                          input bit flushWait, input int holdStall);
        int last;
        last = aokDly + 1 + dokDly;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            mem_en        = 1'b1;
            mem_wen       = wen;
            mem_addr      = addr;
            mem_wdata     = wdata;
            longest_stall = 1'b1;
            data_addr_ok  = (c == aokDly);
            data_data_ok  = (c == last);
            data_rdata    = (c == last) ? rdata : $urandom;
            flush_except  = flushWait && (c == aokDly + 1);
            #1;
            chk("busy_stall", 32'(d_stall), 32'd1);
            chk("req_phase", 32'(data_req), 32'(c <= aokDly));
            if (c <= aokDly) begin
                chk("data_addr", data_addr, refAddr(addr, wen));
                chk("data_size", 32'(data_size), refSize(wen));
                chk("data_wr", 32'(data_wr), 32'(wen != 4'b0000));
                if (wen != 4'b0000) chk("data_wdata", data_wdata, wdata);
            end
        end
        expReqs++;
        if (flushWait) begin
            @(negedge clk);
            quiet();
            mem_en = 1'b0;
            longest_stall = 1'b0;
            #1;
            chk("flush_stall", 32'(d_stall), 32'd0);
            chk("flush_req", 32'(data_req), 32'd0);
            chk("flush_readdata", readdata, prevRead);
        end else begin
            prevRead = rdata;
            for (int h = 0; h <= holdStall; h++) begin
                @(negedge clk);
                quiet();
                longest_stall = (h < holdStall);
                #1;
                chk("done_stall", 32'(d_stall), 32'd0);
                chk("done_req", 32'(data_req), 32'd0);
                chk("done_readdata", readdata, rdata);
            end
        end
    endtask

    initial begin
        logic [3:0] wenList [8];
        wenList = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        // Reset with all inputs idle
        rst = 1'b0;
        mem_en = 1'b0;
        mem_wen = 4'b0;
        mem_addr = 32'h0;
        mem_wdata = 32'h0;
        longest_stall = 1'b0;
        quiet();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_readdata", readdata, 32'h0);

        // Load word from kseg0: addr_ok in the 2nd cycle, data_ok two cycles later
        access(4'b0000, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, 0);
        idle(1);

        // Store halfword through kseg1
        access(4'b1100, 32'hA000_0102, 32'h1234_0000, 32'h5555_5555, 0, 0, 1'b0, 0);
        idle(1);

        // Load completes while the pipeline is frozen for three more cycles
        access(4'b0000, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 3);
        idle(1);

        // Flush in WAIT: data discarded, readdata keeps the previous word
        access(4'b0000, 32'h0000_3000, 32'h0, 32'h0BAD_0BAD, 0, 2, 1'b1, 0);
        idle(1);

        // Back-to-back load then store with no idle gap in between
        seenReqs = 0;
        expReqs = 0;
        access(4'b0000, 32'h9000_0040, 32'h0, 32'h1111_2222, 0, 0, 1'b0, 0);
        access(4'b1111, 32'h0000_0044, 32'hA5A5_5A5A, 32'h0, 1, 0, 1'b0, 1);
        idle(1);
        chk("b2b_req_count", 32'(seenReqs), 32'(expReqs));

        // Reset asserted while the request is still waiting for addr_ok
        @(negedge clk);
        quiet();
        mem_en = 1'b1;
        mem_wen = 4'b0000;
        mem_addr = 32'h0000_1000;
        longest_stall = 1'b1;
        #1;
        chk("pre_rst_req", 32'(data_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("req_before_rst_edge", 32'(data_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        mem_en = 1'b0;
        longest_stall = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h7777_7777;
        #1;
        chk("mid_rst_req", 32'(data_req), 32'd0);
        chk("mid_rst_stall", 32'(d_stall), 32'd0);
        chk("mid_rst_readdata", readdata, 32'h0);
        prevRead = 32'h0;
        idle(1);

        // Randomised accesses with random handshake timing, flushes and freezes
        seenReqs = 0;
        expReqs = 0;
        for (int n = 0; n < 24; n++) begin
            logic [3:0]  wen;
            logic [31:0] addr;
            wen  = wenList[$urandom_range(0, 7)];
            addr = $urandom;
            access(wen, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);
        chk("rand_req_count", 32'(seenReqs), 32'(expReqs));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
